mem_writer: RTL

MEM_WRITER -- requirements
Module: mem_writer

---
 rtl/mem_writer_pkg.sv | 15 +
 rtl/mem_writer_check.sv | 33 +++
 rtl/mem_writer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_writer_pkg.sv
// Shared constants and FSM state encoding for the burst memory writer.
package mem_writer_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_BEATS  = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_writer_check.sv
// Readback comparator: flags any beat whose read data differs from the written word.
// The mismatch output already includes the beat being compared this cycle.
module mem_writer_check
    import mem_writer_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cmp_en,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] expected,
    output logic              mismatch
);

    logic sticky_reg;
    logic hit;

    assign hit      = cmp_en && (rdata != expected);
    assign mismatch = sticky_reg | hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_reg <= 1'b0;
        end else if (clear) begin
            sticky_reg <= 1'b0;
        end else if (hit) begin
            sticky_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_writer.sv
// Writes a BEATS-word request to consecutive memory addresses, then pulses HANDSHAKE.
// Define MEM_WRITER_VERIFY_EN to read every beat back and report mismatches on ERROR.
module mem_writer
    import mem_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic [BEATS*WORD_W-1:0] DATA,
    output logic                    BUSY,
    output logic                    HANDSHAKE,
    output logic                    ERROR,
    output logic [ADDR_W-1:0]       MEM_ADDRESS,
    output logic [WORD_W-1:0]       MEM_WDATA,
    output logic                    MEM_WE,
    input  logic [WORD_W-1:0]       MEM_RDATA
);

    localparam int CNT_W = $clog2(BEATS + 1);

    state_t                  state_reg;
    logic                    busy_reg;
    logic                    hs_reg;
    logic                    we_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [WORD_W-1:0]       wdata_reg;
    logic [ADDR_W-1:0]       base_reg;
    logic [BEATS*WORD_W-1:0] data_reg;
    logic [CNT_W-1:0]        beat_reg;
    logic                    accept;

    logic [WORD_W-1:0] beat_words [BEATS];

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beat_words[gi] = data_reg[gi*WORD_W +: WORD_W];
    end

    assign accept = (state_reg == S_IDLE) && ENABLE;

`ifdef MEM_WRITER_VERIFY_EN
    logic [CNT_W-1:0] vcnt_reg;
    logic             err_reg;
    logic             chk_mismatch;

    // Read data for the read issued at vcnt-1 arrives while vcnt is nonzero.
    mem_writer_check #(
        .WORD_W (WORD_W)
    ) u_check (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (accept),
        .cmp_en   ((state_reg == S_VERIFY) && (vcnt_reg != '0)),
        .rdata    (MEM_RDATA),
        .expected (beat_words[vcnt_reg - CNT_W'(1)]),
        .mismatch (chk_mismatch)
    );

    assign ERROR = err_reg;
`else
    logic unused_rdata;
    assign unused_rdata = ^MEM_RDATA;
    assign ERROR        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            hs_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            base_reg  <= '0;
            data_reg  <= '0;
            beat_reg  <= '0;
`ifdef MEM_WRITER_VERIFY_EN
            vcnt_reg  <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            hs_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        // Beat 0 is presented straight from the inputs so it lands in the first busy cycle.
                        base_reg  <= ADDRESS;
                        data_reg  <= DATA;
                        busy_reg  <= 1'b1;
                        we_reg    <= 1'b1;
                        addr_reg  <= ADDRESS;
                        wdata_reg <= DATA[WORD_W-1:0];
                        beat_reg  <= CNT_W'(1);
                        state_reg <= S_WRITE;
`ifdef MEM_WRITER_VERIFY_EN
                        err_reg   <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    if (beat_reg == CNT_W'(BEATS)) begin
                        we_reg <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
                        addr_reg  <= base_reg;
                        vcnt_reg  <= '0;
                        state_reg <= S_VERIFY;
`else
                        hs_reg    <= 1'b1;
                        state_reg <= S_DONE;
`endif
                    end else begin
                        addr_reg  <= base_reg + ADDR_W'(beat_reg);
                        wdata_reg <= beat_words[beat_reg];
                        beat_reg  <= beat_reg + CNT_W'(1);
                    end
                end
                S_VERIFY: begin
`ifdef MEM_WRITER_VERIFY_EN
                    if (vcnt_reg == CNT_W'(BEATS)) begin
                        hs_reg    <= 1'b1;
                        err_reg   <= chk_mismatch;
                        state_reg <= S_DONE;
                    end else begin
                        vcnt_reg <= vcnt_reg + CNT_W'(1);
                        if (vcnt_reg < CNT_W'(BEATS - 1)) begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
`else
                    state_reg <= S_IDLE;
`endif
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign BUSY        = busy_reg;
    assign HANDSHAKE   = hs_reg;
    assign MEM_WE      = we_reg;
    assign MEM_ADDRESS = addr_reg;
    assign MEM_WDATA   = wdata_reg;

endmodule
